// File: rtl/eip_unit.sv
// Instruction-pointer unit: advance, jumps, call/return through a circular return-address stack.
// Optional trace of the last taken transfer is enabled by defining EIP_TRACE_EN.
module eip_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 8
) (
  input  logic                           clock_5,
  input  logic                           reset,
  input  logic [2:0]                     op,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic [3:0]                     len,
  input  logic [WIDTH-1:0]               target,
  input  logic                           call_rel,
  input  logic                           fault_clear,
  output logic [WIDTH-1:0]               eip,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
`ifdef EIP_TRACE_EN
  output logic [WIDTH-1:0]               last_from,
  output logic [WIDTH-1:0]               last_to,
`endif
  output logic                           fault
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] RAS_FULL_COUNT = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADV  = 3'd1;
  localparam logic [2:0] OP_JABS = 3'd2;
  localparam logic [2:0] OP_JREL = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t           state;
  logic [PW-1:0]    wp;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic             accept;
  logic [WIDTH-1:0] next_seq;
  logic [WIDTH-1:0] rel_dest;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             do_push;
  logic             do_pop;
  logic             go_fault;
  logic             transfer;
  logic [WIDTH-1:0] eip_next;

  assign accept    = op_valid && op_ready;
  assign next_seq  = eip + WIDTH'(len);
  assign rel_dest  = next_seq + target;
  assign ras_top   = ras_mem[wp - PW'(1)];
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == RAS_FULL_COUNT);

  always_comb begin
    eip_next = eip;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    go_fault = 1'b0;
    transfer = 1'b0;
    if (accept) begin
      case (op)
        OP_NOP: eip_next = eip;
        OP_ADV: eip_next = next_seq;
        OP_JABS: begin
          eip_next = target;
          transfer = 1'b1;
        end
        OP_JREL: begin
          eip_next = rel_dest;
          transfer = 1'b1;
        end
        OP_CALL: begin
          eip_next = call_rel ? rel_dest : target;
          do_push  = 1'b1;
          transfer = 1'b1;
        end
        OP_RET: begin
          if (ras_empty) begin
            go_fault = 1'b1;
          end else begin
            eip_next = ras_top;
            do_pop   = 1'b1;
            transfer = 1'b1;
          end
        end
        default: go_fault = 1'b1;
      endcase
    end
  end

  // op_ready and fault are registered alongside the state so they never glitch.
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      op_ready     <= 1'b1;
      fault        <= 1'b0;
      eip          <= RESET_VECTOR;
      wp           <= '0;
      ras_count    <= '0;
      ras_overflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          eip <= eip_next;
          if (go_fault) begin
            state    <= FAULT;
            op_ready <= 1'b0;
            fault    <= 1'b1;
          end
          if (do_push) begin
            wp <= wp + PW'(1);
            if (ras_full) begin
              ras_overflow <= 1'b1;
            end else begin
              ras_count <= ras_count + CW'(1);
            end
          end
          if (do_pop) begin
            wp        <= wp - PW'(1);
            ras_count <= ras_count - CW'(1);
          end
        end
        FAULT: begin
          if (fault_clear) begin
            state    <= RUN;
            op_ready <= 1'b1;
            fault    <= 1'b0;
          end
        end
        default: begin
          state    <= FAULT;
          op_ready <= 1'b0;
          fault    <= 1'b1;
        end
      endcase
    end
  end

  // Stack contents are not reset; only wp/ras_count define which entries are live.
  always_ff @(posedge clock_5) begin
    if (do_push) begin
      ras_mem[wp] <= next_seq;
    end
  end

`ifdef EIP_TRACE_EN
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      last_from <= RESET_VECTOR;
      last_to   <= RESET_VECTOR;
    end else if (transfer) begin
      last_from <= eip;
      last_to   <= eip_next;
    end
  end
`endif

endmodule

// File: doc/eip_unit.md
Name: eip_unit

Overview:
- Parametrised instruction-pointer unit; successor to the single write-port EIP register.
- Holds EIP and advances it by instruction length. Also performs absolute and relative jumps, and call/return through an internal return-address stack (RAS).
- Sits between decode/execute and the fetch address path. Provides a valid/ready handshake and a fault state.

Parameters:
- WIDTH, 32, EIP and address width in bits.
- RESET_VECTOR, 0, EIP value loaded on reset.
- RAS_DEPTH, 8, number of return-stack entries; power of two, at least 2.

Ports:
- clock_5  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- op  in  3  0 NOP, 1 ADV, 2 JABS, 3 JREL, 4 CALL, 5 RET; 6 and 7 are illegal.
- op_valid  in  1  op/len/target are valid this cycle.
- op_ready  out  1  unit accepts an op this cycle.
- len  in  4  instruction length in bytes, 0..15.
- target  in  WIDTH  absolute target, or signed displacement for JREL/CALL-relative.
- call_rel  in  1  CALL target is relative (1) or absolute (0).
- fault_clear  in  1  leaves the FAULT state.
- eip  out  WIDTH  current instruction pointer.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_overflow  out  1  sticky; set when a CALL overwrote the oldest entry.
- fault  out  1  high while in the FAULT state.

Behaviour:
- Reset (reset=0, asynchronous):
  - eip=RESET_VECTOR, ras_count=0, ras_overflow=0, fault=0, state=RUN, RAS pointer=0.
  - RAS contents are don't-care.
  - op_ready=1 in the first cycle after release.
- Transfer: an op executes only when op_valid && op_ready at a posedge. Results are visible on eip one cycle later; there are no multi-cycle ops.
- next = eip + len. All arithmetic is modulo 2^WIDTH; wrap-around is silent.
- NOP: no change.
- ADV: eip <= next.
- JABS: eip <= target.
- JREL: eip <= next + target, with target taken as two's-complement.
- CALL:
  - push next onto the RAS.
  - eip <= call_rel ? next+target : target.
- RET: eip <= popped entry (most recently pushed).
- RAS is a circular buffer with write pointer wp:
  - push writes entry[wp] and increments wp.
  - pop decrements wp and reads entry[wp-1].
- CALL when ras_count==RAS_DEPTH: overwrites the oldest entry; ras_count stays RAS_DEPTH; ras_overflow<=1 (sticky until reset).
- RET when ras_count==0: eip unchanged, RAS unchanged, state -> FAULT.
- Illegal op (6/7): eip unchanged, state -> FAULT.
- State machine:
  - RUN: op_ready=1, fault=0. A RET on empty RAS or an illegal op moves to FAULT.
  - FAULT: op_ready=0, fault=1, eip frozen. fault_clear=1 at posedge moves to RUN; op_ready=1 the next cycle. ras_overflow is not cleared.
- fault_clear in RUN has no effect.
- Only reset clears ras_overflow.
- Reset asserted mid-operation overrides everything, including an op accepted the same edge.

Optional Feature:
- Macro EIP_TRACE_EN.
- When defined, adds two outputs:
  - last_from  out  WIDTH: eip value before the most recent taken JABS/JREL/CALL/RET.
  - last_to  out  WIDTH: resulting eip of that transfer.
- Both update in the same cycle as eip, reset to RESET_VECTOR, and are unchanged by NOP/ADV and faults.
- When not defined, the ports and registers are absent and all other behaviour is identical.

Test Plan:
- Reset release with RESET_VECTOR=0x1000 -> eip=0x1000, ras_count=0, fault=0, op_ready=1.
- From 0x1000: ADV len=3, ADV len=5 -> eip 0x1003, then 0x1008. With eip=0xFFFFFFFE, ADV len=4 -> eip=0x00000002.
- eip=0x2000, JREL len=2 target=0xFFFFFFF0 -> eip=0x1FF2. JABS target=0x4000 -> eip=0x4000.
- eip=0x100:
  - CALL len=5 abs target=0x800 -> eip=0x800, ras_count=1.
  - CALL len=3 rel target=0x10 from 0x800 -> eip=0x813, ras_count=2.
  - RET -> eip=0x803; RET -> eip=0x105; ras_count=0.
- RAS_DEPTH=8, nine CALLs pushing return addresses A1..A9 -> ras_count=8, ras_overflow=1. Eight RETs return A9..A2, then a ninth RET -> fault=1, op_ready=0, eip unchanged.
- In FAULT, hold op_valid=1 with ADV -> eip frozen. fault_clear pulse -> RUN, next ADV accepted. Assert reset while op_valid -> eip=RESET_VECTOR immediately, without waiting for a clock edge.
